// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared W-bit register.
// One requester is granted at a time; its word is loaded, acknowledged, and released before re-arbitration.
module dff_share_arbiter #(
    parameter int unsigned     N       = 4,
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0,
    localparam int unsigned    IDW     = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N-1:0]       req_i,
    input  logic [N*W-1:0]     wdata_i,
    output logic [N-1:0]       gnt_o,
    output logic [IDW-1:0]     gnt_id_o,
    output logic               ack_o,
    output logic               busy_o,
    output logic [W-1:0]       q_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           ack_q, ack_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   q_q, q_d;

    logic [IDW-1:0] win_c;
    logic           found_c;
    int             idx_c;

    // First set request bit scanning from ptr upward, wrapping past N-1 to 0.
    always_comb begin
        win_c   = '0;
        found_c = 1'b0;
        idx_c   = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx_c = int'(ptr_q) + k;
            if (idx_c >= int'(N)) begin
                idx_c = idx_c - int'(N);
            end
            if (!found_c && req_i[idx_c[IDW-1:0]]) begin
                found_c = 1'b1;
                win_c   = idx_c[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        ack_d    = 1'b0;
        q_d      = q_q;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d  = GRANT;
                    gnt_d    = N'(1) << win_c;
                    gnt_id_d = win_c;
                end
            end
            GRANT: begin
                if (req_i[gnt_id_q]) begin
                    q_d     = wdata_i[int'(gnt_id_q)*int'(W) +: W];
                    ack_d   = 1'b1;
                    state_d = WAIT_REL;
                end else begin
                    // Withdrawn before the load: ptr stays so the same scan repeats.
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (!req_i[gnt_id_q]) begin
                    gnt_d   = '0;
                    ptr_d   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            q_q      <= RST_VAL;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            q_q      <= q_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign ack_o    = ack_q;
    assign busy_o   = busy_q;
    assign q_o      = q_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_dff_share_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_id;
    logic           ack;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   word [N];

    int checks = 0;
    int passes = 0;

    assign wdata = {word[3], word[2], word[1], word[0]};

    dff_share_arbiter #(.N(N), .W(W), .RST_VAL(8'h00)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .ack_o    (ack),
        .busy_o   (busy),
        .q_o      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: owner < 0 means no transaction; age 0 is the grant cycle, later cycles await release.
    int          m_owner, m_age, m_ptr, m_id, m_c;
    logic        m_ack;
    logic [W-1:0] m_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_id = 0; m_ack = 1'b0; m_q = 8'h00;
        end else if (m_owner < 0) begin
            m_ack = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                m_c = (m_ptr + k) % int'(N);
                if (m_owner < 0 && req[m_c]) m_owner = m_c;
            end
            if (m_owner >= 0) begin
                m_id  = m_owner;
                m_age = 0;
            end
        end else if (m_age == 0) begin
            if (req[m_owner]) begin
                m_q   = word[m_owner];
                m_ack = 1'b1;
                m_age = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_ack = 1'b0;
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % int'(N);
                m_owner = -1;
            end
        end
    end

    logic [N-1:0] exp_gnt;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_gnt = '0;
            if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
            chk("model_gnt", 32'(gnt), 32'(exp_gnt));
            chk("model_gnt_id", 32'(gnt_id), 32'(m_id));
            chk("model_ack", 32'(ack), 32'(m_ack));
            chk("model_busy", 32'(busy), 32'(m_owner >= 0));
            chk("model_q", 32'(q), 32'(m_q));
        end
    end

    logic [W-1:0] rr_word [4];
    int           n;

    initial begin
        word[0] = 8'h11; word[1] = 8'h22; word[2] = 8'hA5; word[3] = 8'h44;
        rr_word[0] = 8'h11; rr_word[1] = 8'h22; rr_word[2] = 8'hA5; rr_word[3] = 8'h44;
        req   = '0;
        rst_n = 1'b1;
        #1;
        // Reset takes effect with no clock edge.
        rst_n = 1'b0;
        req   = 4'hF;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_q", 32'(q), 32'h00);
        req = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Round-robin: all hold req, each releases after its ack and re-requests.
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int e;
            e = i % 4;
            n = 0;
            do begin
                tick();
                n++;
            end while (gnt == '0 && n < 8);
            chk("rr_wait", 32'(n < 8), 32'h1);
            chk("rr_gnt", 32'(gnt), 32'h1 << e);
            tick();
            chk("rr_ack", 32'(ack), 32'h1);
            chk("rr_q", 32'(q), 32'(rr_word[e]));
            req[e] = 1'b0;
            tick();
            if (i < 4) req[e] = 1'b1;
            else req = '0;
        end
        tick();

        // Single requester 2.
        req = 4'b0100;
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_gnt_id", 32'(gnt_id), 32'h2);
        tick();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_q", 32'(q), 32'hA5);
        req = '0;
        tick();
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_busy", 32'(busy), 32'h0);
        chk("single_rel_ack", 32'(ack), 32'h0);

        // Wrap-around: ptr=3 so requester 3 beats 0, then 0 wins from ptr=0.
        req = 4'b1001;
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        tick();
        chk("wrap_q3", 32'(q), 32'h44);
        req = 4'b0001;
        tick();
        chk("wrap_idle", 32'(busy), 32'h0);
        chk("wrap_id_hold", 32'(gnt_id), 32'h3);
        req = 4'b1001;
        tick();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("wrap_q0", 32'(q), 32'h11);
        req = '0;
        tick();

        // Abort during GRANT; ptr must not advance.
        req = 4'b0010;
        tick();
        chk("abort_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("abort_gnt_clr", 32'(gnt), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_q", 32'(q), 32'h11);
        req = 4'b0011;
        tick();
        chk("abort_regnt", 32'(gnt), 32'h2);
        tick();
        chk("abort_q1", 32'(q), 32'h22);
        req = '0;
        tick();

        // Reset while holding in WAIT_REL.
        word[2] = 8'h3C;
        req = 4'b0100;
        tick();
        tick();
        chk("midrst_q", 32'(q), 32'h3C);
        tick();
        chk("midrst_wait_busy", 32'(busy), 32'h1);
        chk("midrst_wait_ack", 32'(ack), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_q0", 32'(q), 32'h00);
        chk("midrst_gnt0", 32'(gnt), 32'h0);
        chk("midrst_busy0", 32'(busy), 32'h0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("postrst_gnt", 32'(gnt), 32'h1);
        tick();
        chk("postrst_q", 32'(q), 32'h11);
        req = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
